mdu_div_unit: RTL and testbench
===============================

Name: mdu_div_unit

Overview:
Iterative radix-2 restoring divider implementing RV32M DIV, DIVU, REM and REMU.
- Sits directly downstream of the register file: operands come from read_data1 (dividend) and read_data2 (divisor).
- The result returns on the write-back path to the register file's write_data.
- While dividing, it holds the single-cycle core through the shared Stall network so the PC and register write are frozen.

Parameters:
XLEN, 32, operand/result width.
CNT_W, 5, iteration counter width (must equal $clog2(XLEN)).

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  decoded M-ext divide instruction present this cycle (level, held by core while stalled)
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
dividend  input  XLEN  rs1 value
divisor  input  XLEN  rs2 value
kill  input  1  flush (trap/redirect); aborts in-flight operation
stall  output  1  OR'd into core Stall; combinational
busy  output  1  state != IDLE
done  output  1  result valid this cycle; registered, one-cycle pulse
result  output  XLEN  quotient or remainder; valid only when done=1

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, done=0, result=0, all internal registers 0. busy=0, stall=0.
- States: IDLE, CALC, DONE.
- IDLE, start=1, kill=0:
  - Latch op, dividend sign, divisor sign, |dividend| and |divisor|. Magnitudes are unsigned for DIVU/REMU and two's-complement abs for DIV/REM; abs(0x80000000) = 0x80000000 as unsigned.
  - divisor==0: fast path to DONE with preloaded result. DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend unchanged.
  - Otherwise: clear remainder register, counter=0, go to CALC.
- CALC, one step per cycle, MSB first:
  - rem_shift = {rem[XLEN-2:0], quo[XLEN-1]}; quo <<= 1.
  - If rem_shift >= |divisor|: rem = rem_shift - |divisor|, quo[0]=1; else rem = rem_shift.
  - After XLEN steps (counter==XLEN-1 on the edge), go to DONE.
- Transition into DONE registers result with sign fix:
  - DIV: quotient negated if the signs differ.
  - REM: remainder negated if the dividend is negative.
  - DIVU/REMU: unsigned values, no fix.
  - Overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF) needs no special path: quotient=0x80000000, remainder=0. The bench checks it explicitly.
- DONE: done=1, go to IDLE unconditionally. start is ignored in DONE, because it is the same instruction still in decode.
- stall = (state==IDLE & start & ~kill) | (state==CALC). stall=0 in DONE, so the core commits result that cycle.
- Latency:
  - Normal: start seen in cycle 0, done in cycle XLEN+1 (33). stall is high for cycles 0..32.
  - Divide-by-zero: done in cycle 1.
- kill in any state: next state IDLE, done=0, no result. kill has priority over start and over the CALC->DONE transition.
- Back-to-back: a new start is accepted in the IDLE cycle immediately after DONE.
- Input operands may change after the start cycle; only latched values are used.

Decomposition:
- Package mdu_pkg: op encodings (OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11), state encoding (IDLE, CALC, DONE), XLEN default.
- One combinational sub-module, div_step: inputs rem, quo, divisor magnitude; outputs next rem and quo for one restoring iteration.
- FSM, counter, operand latch and sign fix stay in mdu_div_unit.

Test Plan:
- DIVU 100/7: start cycle 0. Required: stall=1 for cycles 0..32, done=1 in cycle 33, result=14. Repeat as REMU: result=2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Divide by zero: DIV 0xFFFFFFF9/0 -> done in cycle 1, result 0xFFFFFFFF. REMU 5/0 -> 5. stall high only in cycle 0.
- kill asserted in cycle 10 of CALC -> next cycle IDLE, busy=0, no done pulse. A following DIVU 9/3 completes correctly with result 3.
- reset pulsed asynchronously mid-CALC (between edges) -> busy, done, stall fall immediately and result=0. The next operation completes in 33 cycles.
- Back-to-back DIVU 0xFFFFFFFF/1 then DIVU 0xFFFFFFFF/0xFFFFFFFF with start held through DONE. Required: two done pulses, 34 cycles apart, results 0xFFFFFFFF then 1; no extra operation triggered from DONE.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and default width for the divide unit
package mdu_pkg;
  localparam int DEF_XLEN = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/mdu_div_step.sv
// div_step: one restoring iteration; in rem, quo, dmag (divisor magnitude); out rem_n, quo_n (one extra bit keeps the compare exact)
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dmag,
  output logic [XLEN-1:0] rem_n,
  output logic [XLEN-1:0] quo_n
);
  logic [XLEN:0] sh, diff;
  assign sh = {rem, quo[XLEN-1]};
  assign diff = sh - {1'b0, dmag};
  assign rem_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_n = {quo[XLEN-2:0], ~diff[XLEN]};
endmodule

// File: rtl/mdu_div_unit.sv
// mdu_div_unit: RV32M DIV/DIVU/REM/REMU radix-2 restoring divider; in clk, reset(async), start, op, dividend, divisor, kill; out stall, busy, done, result
module mdu_div_unit import mdu_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic rem_sel, sa, sb, a_neg, b_neg, take, last;
  logic [XLEN-1:0] dmag, rem, quo, rem_n, quo_n, amag_in, bmag_in, val, res_fix;
  div_step #(.XLEN(XLEN)) u_step (
    .rem(rem),
    .quo(quo),
    .dmag(dmag),
    .rem_n(rem_n),
    .quo_n(quo_n)
  );
  assign a_neg = ~op[0] & dividend[XLEN-1];
  assign b_neg = ~op[0] & divisor[XLEN-1];
  assign amag_in = a_neg ? -dividend : dividend;
  assign bmag_in = b_neg ? -divisor : divisor;
  assign take = (state == IDLE) & start & ~kill;
  assign last = cnt == CNT_W'(XLEN - 1);
  assign val = rem_sel ? rem_n : quo_n;
  assign res_fix = (rem_sel ? sa : sa ^ sb) ? -val : val;
  assign stall = take | (state == CALC);
  assign busy = state != IDLE;
  always_comb begin
    state_n = IDLE;
    if (!kill)
      state_n = (state == IDLE) ? (start ? (divisor == '0 ? DONE : CALC) : IDLE) :
                (state == CALC) ? (last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      done <= 1'b0;
      result <= '0;
      rem_sel <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      dmag <= '0;
      rem <= '0;
      quo <= '0;
    end else begin
      done <= state_n == DONE;
      if (take) begin
        rem_sel <= op[1];
        sa <= a_neg;
        sb <= b_neg;
        dmag <= bmag_in;
        quo <= amag_in;
        rem <= '0;
        cnt <= '0;
        if (divisor == '0) result <= op[1] ? dividend : '1;
      end else if (state == CALC && !kill) begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
        if (last) result <= res_fix;
      end
    end
  end
endmodule

// File: tb/tb_mdu_div_unit.sv
// tb_mdu_div_unit: scoreboard bench for mdu_div_unit with directed vectors, kill, async reset and back-to-back cases
module tb_mdu_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic kill = 1'b0;
  logic stall, busy, done;
  logic [31:0] result;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [63:0] sb_q[$];
  mdu_div_unit dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .dividend(dividend),
    .divisor(divisor),
    .kill(kill),
    .stall(stall),
    .busy(busy),
    .done(done),
    .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("result", {32'd0, result}, {32'd0, e[63:32]});
        check("done_cycle", 64'(cyc), {32'd0, e[31:0]});
      end
    end
  end
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    op = o;
    dividend = a;
    divisor = b;
    start = 1'b1;
    sb_q.push_back({exp, 32'(cyc + lat)});
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      check("stall", {63'd0, stall}, {63'd0, c < lat});
      if (c > 0 && c < lat) check("busy", {63'd0, busy}, 64'd1);
      @(posedge clk);
      #1;
      if (c == 0) begin
        dividend = $urandom;
        divisor = $urandom;
      end
    end
    start = 1'b0;
  endtask
  task automatic raw_start(input logic [31:0] a, input logic [31:0] b);
    op = 2'b01;
    dividend = a;
    divisor = b;
    start = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    #4 reset = 1'b0;
    @(posedge clk);
    #1;
    issue(2'b01, 32'd100, 32'd7, 32'd14, 33);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 33);
    issue(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    issue(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    issue(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
    issue(2'b00, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1);
    issue(2'b11, 32'd5, 32'd0, 32'd5, 1);
    issue(2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1);
    raw_start(32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    kill = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_busy", {63'd0, busy}, 64'd0);
    check("kill_stall", {63'd0, stall}, 64'd0);
    check("kill_done", {63'd0, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    issue(2'b01, 32'd9, 32'd3, 32'd3, 33);
    raw_start(32'd12345, 32'd17);
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_stall", {63'd0, stall}, 64'd0);
    check("arst_result", {32'd0, result}, 64'd0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    issue(2'b01, 32'd100, 32'd7, 32'd14, 33);
    issue(2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 33);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    check("pending", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
